// File: rtl/microstep_control_pkg.sv
// Shared types and constants for the microstep control FSM.
// Contents: default widths, RV32I major opcodes, FSM state encoding,
// instruction class and trap cause enumerations.
package microstep_control_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int STEP_W_DEF     = 4;
  localparam int STEP_LIMIT_DEF = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_END,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } instr_class_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_TIMEOUT = 2'd2
  } trap_cause_t;

endpackage

// File: rtl/microstep_control_if.sv
// Memory handshake bundle between the control FSM and instruction/data memory.
//  instr      memory -> ctrl  instruction word (valid with mem_ready in FETCH)
//  mem_ready  memory -> ctrl  read data valid / write accepted
//  mem_re     ctrl -> memory  read request
//  mem_we     ctrl -> memory  write request
interface microstep_control_if import microstep_control_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) ();
  logic [XLEN-1:0] instr;
  logic            mem_ready;
  logic            mem_re;
  logic            mem_we;

  modport master (input instr, input mem_ready, output mem_re, output mem_we);
  modport slave  (output instr, output mem_ready, input mem_re, input mem_we);
endinterface

// File: rtl/microstep_control_instr_classify.sv
// Combinational RV32I opcode classifier.
//  opcode   in   ir[6:0]
//  cls      out  instruction class (CLS_NONE when unrecognised)
//  illegal  out  opcode is not one of the supported major opcodes
module instr_classify import microstep_control_pkg::*; (
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/microstep_control.sv
// Multi-cycle instruction sequencer sitting after the negedge step counter.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction class, emits datapath
// strobes, resets the step counter between instructions and uses the step
// count as a per-instruction watchdog.
//  clk, reset      posedge clock, async active-high reset
//  step            current microstep from the step counter
//  halt_req        halt request, only honoured between instructions
//  bus             memory handshake (master side)
//  step_reset      reset to the step counter
//  ir              instruction register
//  ir_we, pc_we, rf_we, alu_imm, pc_branch   datapath strobes
//  halted, trap, trap_cause                  terminal status
//
// state  | meaning
// END    | between instructions, counter held at 0, halt_req sampled
// FETCH  | read request until memory returns the instruction
// DECODE | classify ir, trap on unknown opcode
// EXEC   | ALU step; branches finish here
// MEM    | load/store handshake until mem_ready
// WB     | register file and PC write
// HALT   | halted, left only by reset
// TRAP   | trapped (illegal opcode or watchdog), left only by reset
module microstep_control import microstep_control_pkg::*; #(
  parameter int XLEN       = XLEN_DEF,
  parameter int STEP_W     = STEP_W_DEF,
  parameter int STEP_LIMIT = STEP_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STEP_W-1:0]   step,
  input  logic                halt_req,
  microstep_control_if.master bus,
  output logic                step_reset,
  output logic [XLEN-1:0]     ir,
  output logic                ir_we,
  output logic                pc_we,
  output logic                rf_we,
  output logic                alu_imm,
  output logic                pc_branch,
  output logic                halted,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t       state, state_nx;
  trap_cause_t  cause_q, cause_nx;
  instr_class_t cls;
  logic         illegal;
  logic         timeout;
  logic         ir_load;
  logic         mem_re_q, mem_we_q;
  logic         step_reset_d, ir_we_d, pc_we_d, rf_we_d, alu_imm_d, pc_branch_d;
  logic         mem_re_d, mem_we_d, halted_d, trap_d;

  instr_classify u_classify (
    .opcode  (ir[6:0]),
    .cls     (cls),
    .illegal (illegal)
  );

  assign timeout = (state inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) &&
                   (step == STEP_W'(STEP_LIMIT));
  assign ir_load = (state == ST_FETCH) && (state_nx == ST_DECODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_END;
      cause_q    <= TC_NONE;
      ir         <= '0;
      step_reset <= 1'b1;
      ir_we      <= 1'b0;
      pc_we      <= 1'b0;
      rf_we      <= 1'b0;
      alu_imm    <= 1'b0;
      pc_branch  <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      halted     <= 1'b0;
      trap       <= 1'b0;
    end else begin
      state      <= state_nx;
      cause_q    <= cause_nx;
      if (ir_load) ir <= bus.instr;
      step_reset <= step_reset_d;
      ir_we      <= ir_we_d;
      pc_we      <= pc_we_d;
      rf_we      <= rf_we_d;
      alu_imm    <= alu_imm_d;
      pc_branch  <= pc_branch_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      halted     <= halted_d;
      trap       <= trap_d;
    end
  end

  // Watchdog is checked first so it overrides any transition in the same cycle.
  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    if (timeout) begin
      state_nx = ST_TRAP;
      cause_nx = TC_TIMEOUT;
    end else begin
      case (state)
        ST_END:    if (step == '0) state_nx = halt_req ? ST_HALT : ST_FETCH;
        ST_FETCH:  if (bus.mem_ready) state_nx = ST_DECODE;
        ST_DECODE: begin
          if (illegal) begin
            state_nx = ST_TRAP;
            cause_nx = TC_ILLEGAL;
          end else begin
            state_nx = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_nx = ST_MEM;
            CLS_BRANCH:          state_nx = ST_END;
            default:             state_nx = ST_WB;
          endcase
        end
        ST_MEM:    if (bus.mem_ready) state_nx = (cls == CLS_LOAD) ? ST_WB : ST_END;
        ST_WB:     state_nx = ST_END;
        default:   state_nx = state;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state and registered, so each
  // strobe is visible during the state it belongs to. The store's PC update
  // is the one pulse tied to a transition (MEM -> END) because it cannot be
  // known before the write is accepted.
  always_comb begin
    step_reset_d = state_nx inside {ST_END, ST_HALT, ST_TRAP};
    ir_we_d      = ir_load;
    mem_re_d     = (state_nx == ST_FETCH) || ((state_nx == ST_MEM) && (cls == CLS_LOAD));
    mem_we_d     = (state_nx == ST_MEM) && (cls == CLS_STORE);
    alu_imm_d    = (state_nx == ST_EXEC) &&
                   (cls inside {CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR, CLS_LUI, CLS_AUIPC});
    pc_branch_d  = (state_nx == ST_EXEC) && (cls inside {CLS_BRANCH, CLS_JAL, CLS_JALR});
    rf_we_d      = (state_nx == ST_WB);
    pc_we_d      = ((state_nx == ST_EXEC) && (cls == CLS_BRANCH)) ||
                   (state_nx == ST_WB) ||
                   ((state == ST_MEM) && (state_nx == ST_END));
    halted_d     = (state_nx == ST_HALT);
    trap_d       = (state_nx == ST_TRAP);
  end

  assign bus.mem_re = mem_re_q;
  assign bus.mem_we = mem_we_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_microstep_control.sv
module tb_microstep_control;
  import microstep_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halt_req = 1'b0;
  logic [3:0]  step;
  logic        step_reset, ir_we, pc_we, rf_we, alu_imm, pc_branch, halted, trap;
  logic [31:0] ir;
  logic [1:0]  trap_cause;

  int tests = 0;
  int fails = 0;

  microstep_control_if bus ();

  microstep_control dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .halt_req   (halt_req),
    .bus        (bus),
    .step_reset (step_reset),
    .ir         (ir),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .alu_imm    (alu_imm),
    .pc_branch  (pc_branch),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // Step counter model: negedge counter, cleared by reset or step_reset.
  always @(negedge clk or posedge reset) begin
    if (reset)           step <= 4'd0;
    else if (step_reset) step <= 4'd0;
    else                 step <= step + 4'd1;
  end

  typedef struct {
    logic [31:0] instr;
    int fw, mw;
    bit noise, halt;
    int cyc, rf, pc, re, we;
    bit imm, br, trp;
    int cause;
  } vec_t;

  typedef struct {
    int cyc, rf, pc, re, we, irw, both;
    bit imm, br, done;
  } res_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    halt_req = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs one instruction as memory model; starts in END or FETCH and stops
  // at the first cycle with step_reset high after the instruction started.
  task automatic run_instr(input vec_t v, output res_t r);
    int  fw, mw;
    bit  started, in_mem;
    r = '{default: 0};
    fw = 0; mw = 0; started = 0; in_mem = 0;
    halt_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!step_reset) started = 1;
      if (started) begin
        if (bus.mem_re && bus.mem_we) r.both++;
        if (ir_we) begin r.irw++; in_mem = 1; end
        r.rf += int'(rf_we);
        r.pc += int'(pc_we);
        r.re += int'(bus.mem_re);
        r.we += int'(bus.mem_we);
        if (alu_imm)   r.imm = 1;
        if (pc_branch) r.br = 1;
      end
      if (started && step_reset) begin
        r.done = 1;
        break;
      end
      if (!step_reset) r.cyc++;
      bus.instr = v.instr;
      if (in_mem) halt_req = v.halt;
      if ((bus.mem_re || bus.mem_we) && !in_mem) begin
        bus.mem_ready = (fw == v.fw);
        fw++;
      end else if (bus.mem_re || bus.mem_we) begin
        bus.mem_ready = (mw == v.mw);
        mw++;
      end else begin
        bus.mem_ready = v.noise;
      end
      tick();
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    res_t r;
    int   cnt;
    //             instr        fw mw nz ht cyc rf pc re we imm br trp cause
    vt[0]  = '{32'h00500093, 0, 0, 0, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0}; // ADDI
    vt[1]  = '{32'h0000A103, 0, 3, 0, 0, 8, 1, 1, 5, 0, 1, 0, 0, 0}; // LW, 3 waits
    vt[2]  = '{32'h00112223, 1, 1, 1, 0, 6, 0, 1, 2, 2, 1, 0, 0, 0}; // SW
    vt[3]  = '{32'h00000063, 2, 0, 1, 0, 5, 0, 1, 3, 0, 0, 1, 0, 0}; // BEQ
    vt[4]  = '{32'h002081B3, 0, 0, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0}; // ADD
    vt[5]  = '{32'h0080006F, 0, 0, 0, 0, 4, 1, 1, 1, 0, 0, 1, 0, 0}; // JAL
    vt[6]  = '{32'h000080E7, 1, 0, 1, 0, 5, 1, 1, 2, 0, 1, 1, 0, 0}; // JALR
    vt[7]  = '{32'h123450B7, 0, 0, 0, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0}; // LUI
    vt[8]  = '{32'h00000097, 0, 0, 1, 0, 4, 1, 1, 1, 0, 1, 0, 0, 0}; // AUIPC
    vt[9]  = '{32'h0000A103, 0, 2, 0, 1, 7, 1, 1, 4, 0, 1, 0, 0, 0}; // LW + halt
    vt[10] = '{32'hFFFFFFFF, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1, 1}; // illegal

    bus.instr = '0;
    bus.mem_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset_step_reset", step_reset, 1);
    chk("reset_ir", ir, 0);
    chk("reset_cause", trap_cause, 0);
    chk("reset_strobes", {ir_we, pc_we, bus.mem_re, bus.mem_we, rf_we, alu_imm,
                          pc_branch, halted, trap}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("end_step_reset", step_reset, 1);
    chk("end_mem_re", bus.mem_re, 0);
    tick();
    chk("fetch_mem_re", bus.mem_re, 1);
    chk("fetch_step_reset", step_reset, 0);

    for (int i = 0; i < 11; i++) begin
      run_instr(vt[i], r);
      chk($sformatf("v%0d_done", i), r.done, 1);
      chk($sformatf("v%0d_cycles", i), r.cyc, vt[i].cyc);
      chk($sformatf("v%0d_rf_we", i), r.rf, vt[i].rf);
      chk($sformatf("v%0d_pc_we", i), r.pc, vt[i].pc);
      chk($sformatf("v%0d_mem_re", i), r.re, vt[i].re);
      chk($sformatf("v%0d_mem_we", i), r.we, vt[i].we);
      chk($sformatf("v%0d_re_we_both", i), r.both, 0);
      chk($sformatf("v%0d_ir_we", i), r.irw, 1);
      chk($sformatf("v%0d_alu_imm", i), r.imm, vt[i].imm);
      chk($sformatf("v%0d_pc_branch", i), r.br, vt[i].br);
      chk($sformatf("v%0d_ir", i), ir, vt[i].instr);
      chk($sformatf("v%0d_trap", i), trap, vt[i].trp);
      chk($sformatf("v%0d_cause", i), trap_cause, vt[i].cause);
      if (vt[i].halt) begin
        tick();
        chk($sformatf("v%0d_halted", i), halted, 1);
        chk($sformatf("v%0d_halt_step_reset", i), step_reset, 1);
      end
      if (vt[i].halt || vt[i].trp) begin
        bus.mem_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
          tick();
          cnt += int'(rf_we) + int'(pc_we) + int'(bus.mem_re) + int'(bus.mem_we);
        end
        chk($sformatf("v%0d_sticky", i), {trap, halted}, vt[i].trp ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_sticky_strobes", i), cnt, 0);
        do_reset();
      end
    end

    // Watchdog in FETCH: memory never answers.
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (trap) break;
      cnt += int'(bus.mem_re);
      tick();
    end
    chk("wd_fetch_cycles", cnt, 15);
    chk("wd_trap", trap, 1);
    chk("wd_cause", trap_cause, 2);
    chk("wd_mem_re", bus.mem_re, 0);
    do_reset();

    // mem_ready arriving on the step==15 edge: the watchdog wins.
    bus.instr = 32'h00500093;
    tick();
    for (int k = 0; k < 15; k++) begin
      bus.mem_ready = (k == 14);
      tick();
    end
    bus.mem_ready = 1'b0;
    chk("wd_race_trap", trap, 1);
    chk("wd_race_cause", trap_cause, 2);
    chk("wd_race_ir_we", ir_we, 0);
    chk("wd_race_ir", ir, 0);
    do_reset();

    // Async reset in the middle of a load's MEM phase.
    bus.instr = 32'h0000A103;
    tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_pre_mem_re", bus.mem_re, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_step_reset", step_reset, 1);
    chk("rst_mem_ir", ir, 0);
    chk("rst_mem_strobes", {ir_we, pc_we, bus.mem_re, bus.mem_we, rf_we, alu_imm,
                            pc_branch, halted, trap}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("rst_mem_refetch", bus.mem_re, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
